// File: rtl/cdb_writeback_queue.sv
// cdb_writeback_queue: buffers up to three completed functional-unit results
// per cycle and broadcasts them on the common data bus one per cycle, oldest
// first. Results arriving together are ordered multiplier, adder, mem.
//
// Handshake: each input presents a result when its tag bit 7 is set; there is
// no per-input ready, so a result that finds no free slot is dropped and
// flagged on the sticky overflow output. Upstream throttling is done earlier
// through dispatch_stall. On the output side, tag_in_effect bit 7 is the
// broadcast valid and en is the ready: the head entry is consumed only in a
// cycle where both are 1.
module cdb_writeback_queue #(
   parameter int DEPTH       = 8,
   parameter int STALL_LEVEL = DEPTH - 3
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       en,
   input  logic [7:0]                 CDB_tag_multiplier,
   input  logic [7:0]                 CDB_tag_adder,
   input  logic [7:0]                 CDB_tag_mem,
   input  logic [31:0]                CDB_data_multiplier,
   input  logic [31:0]                CDB_data_adder,
   input  logic [31:0]                CDB_data_mem,
   output logic [7:0]                 tag_in_effect,
   output logic [31:0]                data_in_effect,
   output logic                       dispatch_stall,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   // Each slot holds {tag, data}.
   logic [39:0]   store [DEPTH];
   logic [AW-1:0] wp;
   logic [AW-1:0] rp;

   logic          v_mul, v_add, v_mem;
   logic          pop;
   logic [CW-1:0] free;
   logic          acc_mul, acc_add, acc_mem;
   logic [1:0]    n_acc;
   logic          drop;
   logic [AW-1:0] slot_add, slot_mem;
   logic [39:0]   head;

   assign v_mul = CDB_tag_multiplier[7];
   assign v_add = CDB_tag_adder[7];
   assign v_mem = CDB_tag_mem[7];

   // Acceptance: slots freed by this cycle's pop are reusable immediately, and
   // when space runs short the lowest-priority inputs lose out first.
   always_comb begin
      pop     = en & (count != '0);
      free    = CW'(DEPTH) - count + CW'(pop);
      acc_mul = v_mul & (free != '0);
      acc_add = v_add & (free > CW'(acc_mul));
      acc_mem = v_mem & (free > (CW'(acc_mul) + CW'(acc_add)));
      n_acc   = {1'b0, acc_mul} + {1'b0, acc_add} + {1'b0, acc_mem};
      drop    = (v_mul & ~acc_mul) | (v_add & ~acc_add) | (v_mem & ~acc_mem);
   end

   // Accepted results pack into consecutive slots from wp, skipping gaps left
   // by inputs that are idle this cycle.
   always_comb begin
      slot_add = wp + AW'(acc_mul);
      slot_mem = wp + AW'(acc_mul) + AW'(acc_add);
   end

   // Storage write; contents are not reset since count gates every read.
   always_ff @(posedge clk) begin
      if (acc_mul) store[wp]       <= {CDB_tag_multiplier, CDB_data_multiplier};
      if (acc_add) store[slot_add] <= {CDB_tag_adder, CDB_data_adder};
      if (acc_mem) store[slot_mem] <= {CDB_tag_mem, CDB_data_mem};
   end

   // Pointer, occupancy and sticky overflow update; pointers wrap naturally
   // because DEPTH is a power of two.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wp       <= '0;
         rp       <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         wp       <= wp + AW'(n_acc);
         rp       <= rp + AW'(pop);
         count    <= count + CW'(n_acc) - CW'(pop);
         overflow <= overflow | drop;
      end
   end

   // Broadcast the head whenever the queue holds something, even with en low;
   // downstream qualifies it with en. Empty queue drives zeros.
   always_comb begin
      head           = store[rp];
      tag_in_effect  = (count != '0) ? head[39:32] : 8'h00;
      data_in_effect = (count != '0) ? head[31:0]  : 32'h0;
   end

   // Stall from registered occupancy only, no hysteresis.
   always_comb begin
      dispatch_stall = (count >= CW'(STALL_LEVEL));
   end

endmodule

// File: tb/tb_cdb_writeback_queue.sv
// Bench for cdb_writeback_queue: directed scenarios plus randomized traffic,
// all checked against a queue-based reference model of the buffer.
module tb_cdb_writeback_queue;

   localparam int DEPTH       = 8;
   localparam int STALL_LEVEL = 5;
   localparam int CW          = $clog2(DEPTH + 1);

   logic          clk = 1'b0;
   logic          reset;
   logic          en;
   logic [7:0]    tag_m, tag_a, tag_d;
   logic [31:0]   dat_m, dat_a, dat_d;
   logic [7:0]    tag_in_effect;
   logic [31:0]   data_in_effect;
   logic          dispatch_stall;
   logic [CW-1:0] count;
   logic          overflow;

   int tests = 0;
   int fails = 0;

   // Reference model: entries in broadcast order plus the sticky drop flag.
   logic [39:0] exp_q[$];
   logic        exp_ov;

   // Broadcast log for the ordered-stream scenario.
   logic [7:0]  want_tags[$];
   logic [7:0]  seen_tags[$];
   logic        logging = 1'b0;

   cdb_writeback_queue #(.DEPTH(DEPTH), .STALL_LEVEL(STALL_LEVEL)) dut (
      .clk                 (clk),
      .reset               (reset),
      .en                  (en),
      .CDB_tag_multiplier  (tag_m),
      .CDB_tag_adder       (tag_a),
      .CDB_tag_mem         (tag_d),
      .CDB_data_multiplier (dat_m),
      .CDB_data_adder      (dat_a),
      .CDB_data_mem        (dat_d),
      .tag_in_effect       (tag_in_effect),
      .data_in_effect      (data_in_effect),
      .dispatch_stall      (dispatch_stall),
      .count               (count),
      .overflow            (overflow)
   );

   // Clock
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [39:0] obs, input logic [39:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", name, obs, exp);
      end
   endtask

   // Compare every output against the model's current state.
   task automatic check_outputs(input string name);
      logic [39:0] h;
      h = (exp_q.size() != 0) ? exp_q[0] : 40'h0;
      chk({name, ".tag"},   40'(tag_in_effect),  40'(h[39:32]));
      chk({name, ".data"},  40'(data_in_effect), 40'(h[31:0]));
      chk({name, ".count"}, 40'(count),          40'(exp_q.size()));
      chk({name, ".stall"}, 40'(dispatch_stall), 40'(exp_q.size() >= STALL_LEVEL));
      chk({name, ".ovf"},   40'(overflow),       40'(exp_ov));
   endtask

   // Model of one clock edge: head leaves first, then valid inputs join the
   // tail in mul, add, mem order while space remains.
   task automatic model_edge(input logic e,
                             input logic [7:0] tm, input logic [7:0] ta, input logic [7:0] td,
                             input logic [31:0] dm, input logic [31:0] da, input logic [31:0] dd);
      logic [39:0] ins [3];
      ins[0] = {tm, dm};
      ins[1] = {ta, da};
      ins[2] = {td, dd};
      if (e && exp_q.size() != 0) void'(exp_q.pop_front());
      for (int k = 0; k < 3; k++) begin
         if (ins[k][39]) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(ins[k]);
            else exp_ov = 1'b1;
         end
      end
   endtask

   // Driver: one cycle. Inputs are applied and outputs checked mid-cycle,
   // then the edge is taken and the model advanced.
   task automatic cycle(input string name, input logic e,
                        input logic [7:0] tm, input logic [7:0] ta, input logic [7:0] td,
                        input logic [31:0] dm, input logic [31:0] da, input logic [31:0] dd);
      en = e; tag_m = tm; tag_a = ta; tag_d = td;
      dat_m = dm; dat_a = da; dat_d = dd;
      #1;
      check_outputs(name);
      if (logging && e && tag_in_effect[7]) seen_tags.push_back(tag_in_effect);
      @(posedge clk);
      model_edge(e, tm, ta, td, dm, da, dd);
      #1;
   endtask

   task automatic idle(input string name, input logic e);
      cycle(name, e, 8'h00, 8'h00, 8'h00, 32'h0, 32'h0, 32'h0);
   endtask

   task automatic push1(input string name, input logic e, input logic [7:0] t);
      cycle(name, e, t, 8'h00, 8'h00, $urandom, 32'h0, 32'h0);
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < DEPTH + 2; i++) idle(name, 1'b1);
   endtask

   initial begin
      int wait_cycles;
      logic e;
      logic [7:0] t [3];

      reset = 1'b1; en = 1'b0;
      tag_m = 8'h0; tag_a = 8'h0; tag_d = 8'h0;
      dat_m = 32'h0; dat_a = 32'h0; dat_d = 32'h0;
      exp_ov = 1'b0;

      // Reset at start-up
      repeat (2) @(posedge clk);
      #1;
      check_outputs("por_in_reset");
      reset = 1'b0;
      idle("por_first_cycle", 1'b1);

      // Priority ordering: three results together into an empty queue
      cycle("prio_push", 1'b1, 8'h81, 8'h82, 8'h83, 32'h11, 32'h22, 32'h33);
      chk("prio_c1_tag", 40'(tag_in_effect), 40'h81);
      chk("prio_c1_cnt", 40'(count), 40'd3);
      idle("prio_c1", 1'b1);
      chk("prio_c2_tag", 40'(tag_in_effect), 40'h82);
      idle("prio_c2", 1'b1);
      chk("prio_c3_data", 40'(data_in_effect), 40'h33);
      idle("prio_c3", 1'b1);
      chk("prio_end_cnt", 40'(count), 40'd0);
      idle("prio_empty", 1'b1);

      // Invalid input with live-looking data is ignored
      cycle("inv_push", 1'b1, 8'h00, 8'h05, 8'h00, 32'h0, 32'hDEADBEEF, 32'h0);
      chk("inv_cnt", 40'(count), 40'd0);
      idle("inv_after", 1'b0);

      // Stall threshold: fill to 5 with drain held, then release
      cycle("stall_p3", 1'b0, 8'h90, 8'h91, 8'h92, $urandom, $urandom, $urandom);
      chk("stall_at3", 40'(dispatch_stall), 40'd0);
      cycle("stall_p2", 1'b0, 8'h93, 8'h94, 8'h00, $urandom, $urandom, 32'h0);
      chk("stall_at5", 40'(dispatch_stall), 40'd1);
      idle("stall_hold", 1'b0);
      idle("stall_release", 1'b1);
      chk("stall_at4", 40'(dispatch_stall), 40'd0);
      drain("stall_drain");

      // Overflow: fill to 7, then push 3 with drain held
      for (int i = 0; i < 7; i++) push1("ovf_fill", 1'b0, 8'(8'hA0 + i));
      chk("ovf_cnt7", 40'(count), 40'd7);
      cycle("ovf_push3", 1'b0, 8'hB0, 8'hB1, 8'hB2, $urandom, $urandom, $urandom);
      chk("ovf_cnt8", 40'(count), 40'd8);
      chk("ovf_set", 40'(overflow), 40'd1);
      cycle("ovf_full_pop", 1'b1, 8'hB3, 8'hB4, 8'h00, $urandom, $urandom, 32'h0);
      chk("ovf_still8", 40'(count), 40'd8);
      drain("ovf_drain");
      chk("ovf_sticky", 40'(overflow), 40'd1);

      // Reset mid-operation with 5 entries queued
      for (int i = 0; i < 5; i++) push1("rst_fill", 1'b0, 8'(8'hC0 + i));
      #2 reset = 1'b1;
      #1;
      exp_q.delete();
      exp_ov = 1'b0;
      check_outputs("rst_immediate");
      tag_m = 8'hC9; tag_a = 8'hCA; tag_d = 8'hCB;
      @(posedge clk);
      #1;
      check_outputs("rst_held");
      @(negedge clk);
      reset = 1'b0;
      tag_m = 8'h00; tag_a = 8'h00; tag_d = 8'h00;
      @(posedge clk);
      #1;
      check_outputs("rst_first_cycle");
      idle("rst_empty", 1'b1);

      // Ordered stream of 20 tags with random drain gaps
      want_tags.delete();
      seen_tags.delete();
      logging = 1'b1;
      for (int i = 0; i < 20; i++) begin
         want_tags.push_back(8'(8'h80 + i));
         wait_cycles = $urandom_range(0, 2);
         for (int j = 0; j < wait_cycles; j++) begin
            e = (exp_q.size() >= DEPTH - 1) ? 1'b1 : 1'($urandom_range(0, 1));
            idle("wrap_gap", e);
         end
         e = (exp_q.size() >= DEPTH - 1) ? 1'b1 : ($urandom_range(0, 3) != 0);
         push1("wrap_push", e, 8'(8'h80 + i));
      end
      drain("wrap_drain");
      logging = 1'b0;
      chk("wrap_n_seen", 40'(seen_tags.size()), 40'(want_tags.size()));
      for (int i = 0; i < want_tags.size() && i < seen_tags.size(); i++)
         chk("wrap_order", 40'(seen_tags[i]), 40'(want_tags[i]));
      chk("wrap_no_ovf", 40'(overflow), 40'd0);

      // Randomized traffic: any mix of valid inputs and drain enable
      for (int i = 0; i < 300; i++) begin
         for (int k = 0; k < 3; k++)
            t[k] = {1'($urandom_range(0, 1)), 7'($urandom)};
         cycle("rand", ($urandom_range(0, 3) != 0), t[0], t[1], t[2],
               $urandom, $urandom, $urandom);
      end
      drain("rand_drain");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/cdb_writeback_queue.md
# cdb_writeback_queue

Result buffer between the three functional units (multiplier, adder, memory) and the common data bus. It accepts up to three completed results per cycle. It serializes them onto the CDB at one broadcast per cycle, in fixed priority order. It raises `dispatch_stall` toward the dispatch/decode unit only when buffer occupancy is high, so simultaneous completions no longer force an immediate dispatch stall.

## Interface
- `DEPTH`, default 8: number of entries; power of two, ≥ 4.
- `STALL_LEVEL`, default `DEPTH-3`: occupancy at or above which `dispatch_stall` asserts; must satisfy `1 ≤ STALL_LEVEL ≤ DEPTH-3`.
- `clk` input, 1 bit: single clock, rising edge.
- `reset` input, 1 bit: asynchronous, active-high reset.
- `en` input, 1 bit: drain enable. When 0, the queue holds its head, but pushes are still accepted.
- `CDB_tag_multiplier`, `CDB_tag_adder`, `CDB_tag_mem` input, 8 bits each: result tags; bit 7 = valid.
- `CDB_data_multiplier`, `CDB_data_adder`, `CDB_data_mem` input, 32 bits each: result data.
- `tag_in_effect` output, 8 bits: broadcast tag; bit 7 = valid; 0 when the queue is empty.
- `data_in_effect` output, 32 bits: broadcast data; 0 when the queue is empty.
- `dispatch_stall` output, 1 bit: stall request to dispatch.
- `count` output, `$clog2(DEPTH+1)` bits: current occupancy.
- `overflow` output, 1 bit: sticky flag, set when any result is dropped.

## Operation
- Storage is a circular buffer of `{tag[7:0], data[31:0]}` with write pointer `wp`, read pointer `rp` and `count`. Both pointers wrap modulo `DEPTH`.
- **Push set:** every input whose tag bit 7 = 1. Inputs with bit 7 = 0 are ignored, whatever their data.
- **Enqueue order within a cycle:** multiplier, then adder, then mem. They occupy consecutive slots starting at `wp`.
- **Pop:** `pop = en & (count != 0)`. The head entry is broadcast on `tag_in_effect`/`data_in_effect` during the cycle it is popped.
- **Output when not popping:**
  - Queue empty: outputs are all zero.
  - Queue non-empty with `en` = 0: outputs still show the head entry, but it is not consumed. Downstream must qualify the broadcast with `en`.
- **Free space:** `free = DEPTH - count + pop`.
- **Overflow handling:**
  - Pushes beyond `free` are dropped in reverse priority: mem first, then adder, then multiplier.
  - Any drop sets `overflow`, which stays 1 until `reset`.
- **Next-state update:**
  - `count_next = count + accepted - pop`.
  - `wp += accepted`.
  - `rp += pop`.
- **Stall:** `dispatch_stall = (count >= STALL_LEVEL)`. It is combinational from the registered `count`. The required `STALL_LEVEL ≤ DEPTH-3` bound guarantees room for one cycle of three in-flight completions after the stall is raised.
- **No bypass:** a result pushed in cycle N can be broadcast in cycle N+1 at the earliest.
- **Tag uniqueness:** each tag is broadcast exactly once, in FIFO order. The block performs no tag comparison and no deduplication.

## Timing
- **Reset:** asynchronous assert and release. It clears `wp`, `rp`, `count` and `overflow`. All outputs read 0 while reset is high and in the first cycle after it. Storage contents need not be cleared.
- **Reset mid-operation:** all buffered results are discarded. Pushes presented in the same cycle as the reset are lost.
- **Latency:** input sampled at edge N → broadcast no earlier than cycle N+1.
- **Throughput:** one broadcast per cycle.
- **Head-of-line delay:** with k entries ahead, a result is broadcast k cycles later, provided `en` stays 1.
- **Push into empty queue with `en`=1:** 3 pushes in the same cycle are broadcast on the next 3 consecutive cycles, in mul, add, mem order.
- **Full with pop:** `count = DEPTH` with `en` = 1 → `free = 1`, so only the multiplier result (or the highest-priority valid input) is accepted.
- **Pointer wrap:** an enqueue crossing slot `DEPTH-1` continues at slot 0 with no bubble.
- **`dispatch_stall` timing:** it tracks `count` from the same edge. There is no hysteresis; it deasserts in the first cycle where `count < STALL_LEVEL`.

## Test plan
- **Reset:** assert `reset` mid-cycle with 5 entries queued → outputs, `count` and `overflow` read 0 immediately; after release, empty-queue outputs are 0.
- **Priority ordering:** in one cycle, push mul tag 0x81/data 0x11, add tag 0x82/data 0x22, mem tag 0x83/data 0x33 into an empty queue with `en`=1 → broadcasts 0x81, 0x82, 0x83 on cycles +1, +2, +3; `count` reads 3, 2, 1, 0.
- **Invalid inputs ignored:** `CDB_tag_adder` = 0x05 (bit 7 = 0) with data 0xDEADBEEF → no enqueue, `count` unchanged.
- **Stall threshold** (`DEPTH`=8, `STALL_LEVEL`=5, `en`=0): push 3 then 2 results → `dispatch_stall` = 1 once `count` = 5; set `en`=1 → stall drops the cycle `count` reaches 4.
- **Overflow:** with `count` = 7, `en`=0, push 3 results → only mul accepted, `count` = 8, `overflow` = 1 and sticky. Then with `en`=1, push 2 results → mul accepted, `count` stays 8, the adder result is dropped.
- **Wrap-around:** stream 20 single pushes, each tagged 0x80+i, with `en`=1 and random `en` gaps → all 20 tags are broadcast in order, exactly once, with no loss and `overflow` = 0.
